// File: rtl/bb84_pkg.sv
// Shared types and constants for the BB84 round sequencer.
// Holds the FSM state encoding, the basis encoding and the LFSR polynomial.
package bb84_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    EMIT,
    FINISH
  } state_t;

  localparam logic RECT = 1'b0;
  localparam logic DIAG = 1'b1;

  // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DFLT = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bb84_lfsr16.sv
// 16-bit Fibonacci LFSR, shifts left one step per enabled cycle.
// The state returns to SEED on reset only, so successive sessions continue the sequence.
module bb84_lfsr16
  import bb84_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    state <= SEED;
    else if (step) state <= lfsr_next(state);
  end

endmodule

// File: rtl/bb84_round_sequencer.sv
// Sequences BB84 rounds over a combinational channel: draw bits/bases, settle,
// sample Bob, sift matching-basis rounds into key words and abort on excess errors.
module bb84_round_sequencer
  import bb84_pkg::*;
#(
  parameter int          SETTLE_CYC = 2,
  parameter int          N_ROUNDS   = 64,
  parameter int          KEY_W      = 8,
  parameter int          ERR_MAX    = 2,
  parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             spy_req,
  output logic             busy,
  output logic             done,
  output logic             abort,
  output logic             alice_bit,
  output logic             alice_basis,
  output logic             bob_basis,
  output logic             spy,
  input  logic             bob_bit,
  output logic [KEY_W-1:0] key_word,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [7:0]       sifted_cnt,
  output logic [7:0]       err_cnt
);

  localparam int SW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam int FW = $clog2(KEY_W + 1);

  state_t           state, state_d;
  logic [15:0]      lfsr_q;
  logic [2:0]       draw;
  logic [SW-1:0]    settle_cnt;
  logic [7:0]       round_cnt, round_nx;
  logic [FW-1:0]    fill, fill_nx;
  logic [7:0]       sift_nx, err_nx;
  logic [KEY_W-1:0] key_sr;
  logic             match, mism, over_err;

  bb84_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (state == DRIVE),
    .state (lfsr_q)
  );

  // Low three bits of the post-step LFSR value: {bob_basis, alice_basis, alice_bit}
  assign draw = {lfsr_q[1], lfsr_q[0], ^(lfsr_q & LFSR_TAPS)};

  // Round outcome as it will look after this SAMPLE cycle
  assign match    = (alice_basis == bob_basis);
  assign mism     = match && (bob_bit != alice_bit);
  assign round_nx = round_cnt + 8'd1;
  assign sift_nx  = (match && sifted_cnt != 8'hFF) ? sifted_cnt + 8'd1 : sifted_cnt;
  assign err_nx   = (mism && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
  assign fill_nx  = match ? fill + FW'(1) : fill;
  assign over_err = int'(err_nx) > ERR_MAX;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:   if (start) state_d = DRIVE;
      DRIVE:  state_d = SETTLE;
      SETTLE: if (settle_cnt == SW'(1)) state_d = SAMPLE;
      SAMPLE: begin
        if (over_err)                        state_d = FINISH;
        else if (fill_nx == FW'(KEY_W))      state_d = EMIT;
        else if (round_nx == 8'(N_ROUNDS))   state_d = FINISH;
        else                                 state_d = DRIVE;
      end
      EMIT:   if (key_ready) state_d = (round_cnt == 8'(N_ROUNDS)) ? FINISH : DRIVE;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt  <= '0;
      round_cnt   <= '0;
      fill        <= '0;
      key_sr      <= '0;
      sifted_cnt  <= '0;
      err_cnt     <= '0;
      abort       <= 1'b0;
      spy         <= 1'b0;
      alice_bit   <= 1'b0;
      alice_basis <= 1'b0;
      bob_basis   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          round_cnt  <= '0;
          fill       <= '0;
          key_sr     <= '0;
          sifted_cnt <= '0;
          err_cnt    <= '0;
          abort      <= 1'b0;
          spy        <= spy_req;
        end
        DRIVE: begin
          alice_bit   <= draw[0];
          alice_basis <= draw[1];
          bob_basis   <= draw[2];
          settle_cnt  <= SW'(SETTLE_CYC);
        end
        SETTLE: settle_cnt <= settle_cnt - SW'(1);
        SAMPLE: begin
          round_cnt  <= round_nx;
          sifted_cnt <= sift_nx;
          err_cnt    <= err_nx;
          fill       <= fill_nx;
          if (match)    key_sr <= (key_sr << 1) | KEY_W'(bob_bit);
          if (over_err) abort  <= 1'b1;
        end
        EMIT: if (key_ready) fill <= '0;
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);
  assign key_valid = (state == EMIT);
  assign key_word  = key_sr;

endmodule

// File: tb/tb_bb84_round_sequencer.sv
// Randomized bench for bb84_round_sequencer against a round-level reference model.
module tb_bb84_round_sequencer;

  localparam int          S_A  = 2;
  localparam int          N_A  = 64;
  localparam int          S_B  = 1;
  localparam int          N_B  = 3;
  localparam int          KW   = 8;
  localparam int          EMAX = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, spy_req = 1'b0;
  logic bob_bit = 1'b0, key_ready = 1'b0, sel = 1'b0;
  int   nchk = 0, nerr = 0;
  logic [15:0] ma, mb;

  always #5 clk = ~clk;

  logic a_busy, a_done, a_abort, a_ab, a_aba, a_bba, a_spy, a_kv;
  logic b_busy, b_done, b_abort, b_ab, b_aba, b_bba, b_spy, b_kv;
  logic [7:0] a_kw, a_sc, a_ec, b_kw, b_sc, b_ec;
  logic busy, done, abort, alice_bit, alice_basis, bob_basis, spy, key_valid;
  logic [7:0] key_word, sifted_cnt, err_cnt;

  bb84_round_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .spy_req(spy_req),
    .busy(a_busy), .done(a_done), .abort(a_abort), .alice_bit(a_ab),
    .alice_basis(a_aba), .bob_basis(a_bba), .spy(a_spy), .bob_bit(bob_bit),
    .key_word(a_kw), .key_valid(a_kv), .key_ready(key_ready),
    .sifted_cnt(a_sc), .err_cnt(a_ec)
  );

  bb84_round_sequencer #(.SETTLE_CYC(S_B), .N_ROUNDS(N_B)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .spy_req(spy_req),
    .busy(b_busy), .done(b_done), .abort(b_abort), .alice_bit(b_ab),
    .alice_basis(b_aba), .bob_basis(b_bba), .spy(b_spy), .bob_bit(bob_bit),
    .key_word(b_kw), .key_valid(b_kv), .key_ready(key_ready),
    .sifted_cnt(b_sc), .err_cnt(b_ec)
  );

  assign busy        = sel ? b_busy  : a_busy;
  assign done        = sel ? b_done  : a_done;
  assign abort       = sel ? b_abort : a_abort;
  assign alice_bit   = sel ? b_ab    : a_ab;
  assign alice_basis = sel ? b_aba   : a_aba;
  assign bob_basis   = sel ? b_bba   : a_bba;
  assign spy         = sel ? b_spy   : a_spy;
  assign key_valid   = sel ? b_kv    : a_kv;
  assign key_word    = sel ? b_kw    : a_kw;
  assign sifted_cnt  = sel ? b_sc    : a_sc;
  assign err_cnt     = sel ? b_ec    : a_ec;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Polynomial x^16+x^14+x^13+x^11+1, new bit enters at the bottom
  function automatic logic [15:0] step16(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  function automatic logic [31:0] all_outs();
    return {busy, done, abort, alice_bit, alice_basis, bob_basis, spy, key_valid,
            key_word, sifted_cnt, err_cnt};
  endfunction

  // One session: stall = EMIT cycles held off on the first word, glitch_r = round
  // with a spurious start, rst_r = round whose SETTLE gets a reset
  task automatic run(input bit dsel, input bit spy_en, input int stall,
                     input int glitch_r, input int rst_r, output bit aborted);
    int n, s, sift, err, fill, words;
    logic [7:0]  key;
    logic [15:0] m;
    logic ab, aba, bba, eb, ebit;
    n = dsel ? N_B : N_A;
    s = dsel ? S_B : S_A;
    m = dsel ? mb : ma;
    sift = 0; err = 0; fill = 0; words = 0; key = '0; aborted = 1'b0;
    sel = dsel; spy_req = spy_en; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    spy_req = ~spy_en;
    chk("start_busy", {busy, done, abort, key_valid}, 4'b1000);
    chk("spy_latch", spy, spy_en);
    for (int r = 1; r <= n; r++) begin
      m = step16(m); ab = m[0]; aba = m[1]; bba = m[2];
      @(negedge clk);
      chk("draw", {alice_bit, alice_basis, bob_basis}, {ab, aba, bba});
      if (!spy_en) bob_bit = (aba == bba) ? ab : 1'($urandom);
      else begin
        eb      = 1'($urandom);
        ebit    = (eb == aba) ? ab : 1'($urandom);
        bob_bit = (bba == eb) ? ebit : 1'($urandom);
      end
      if (r == glitch_r) start = 1'b1;
      if (r == rst_r) begin
        rst_n = 1'b0;
        #1 chk("rst_async", all_outs(), 32'h0);
        repeat (2) begin
          @(negedge clk);
          chk("rst_hold", all_outs(), 32'h0);
        end
        rst_n = 1'b1;
        ma = SEED; mb = SEED;
        return;
      end
      repeat (s + 1) begin
        @(negedge clk);
        start = 1'b0;
      end
      if (aba == bba) begin
        if (sift < 255) sift++;
        key = {key[6:0], bob_bit};
        fill++;
        if (bob_bit != ab && err < 255) err++;
      end
      chk("sifted_cnt", sifted_cnt, sift);
      chk("err_cnt", err_cnt, err);
      if (err > EMAX) begin
        chk("abort_fin", {done, abort, key_valid, busy}, 4'b1101);
        @(negedge clk);
        chk("abort_idle", {done, abort, busy, key_valid}, 4'b0100);
        aborted = 1'b1;
        if (dsel) mb = m; else ma = m;
        return;
      end
      if (fill == KW) begin
        for (int k = 0; k <= stall; k++) begin
          chk("emit_valid", {key_valid, done}, 2'b10);
          chk("key_word", key_word, key);
          chk("emit_hold", {alice_bit, alice_basis, bob_basis}, {ab, aba, bba});
          key_ready = (k == stall);
          @(negedge clk);
        end
        key_ready = 1'b0;
        fill = 0; words++; stall = 0;
        chk("emit_drop", key_valid, 1'b0);
      end
      if (r == n) begin
        chk("fin", {done, busy, abort, key_valid}, 4'b1100);
        @(negedge clk);
        chk("idle", {done, busy}, 2'b00);
        chk("words", words, sift / KW);
        chk("hold_cnt", {sifted_cnt, err_cnt}, {8'(sift), 8'(err)});
      end else begin
        chk("next_drive", {done, busy, key_valid}, 3'b010);
      end
    end
    if (dsel) mb = m; else ma = m;
  endtask

  initial begin
    bit ab_flag, got;
    #2 rst_n = 1'b0;
    #1 chk("reset_a", all_outs(), 32'h0);
    sel = 1'b1;
    #1 chk("reset_b", all_outs(), 32'h0);
    sel = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ma = SEED; mb = SEED;

    run(1, 0, 0, 0, 0, ab_flag);   // short session, partial key only
    chk("short_noabort", ab_flag, 1'b0);
    repeat (2) @(negedge clk);
    run(0, 0, 0, 0, 0, ab_flag);   // ideal channel
    chk("ideal_noabort", ab_flag, 1'b0);
    run(0, 0, 10, 0, 0, ab_flag);  // consumer stall on first word
    run(0, 0, 0, 5, 0, ab_flag);   // start while busy
    chk("glitch_noabort", ab_flag, 1'b0);
    run(0, 0, 0, 0, 20, ab_flag);  // reset mid-SETTLE
    run(0, 0, 0, 0, 0, ab_flag);   // restarts from the seed
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) run(0, 1, 0, 0, 0, got);
    chk("spy_abort", got, 1'b1);
    run(0, 0, 0, 0, 0, ab_flag);   // abort cleared by the next start
    chk("post_abort", ab_flag, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
